draw_sequencer: RTL and testbench
=================================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter DEPTH, 8, command FIFO depth in entries (power of two, 2 to 64).
REQ-002 Parameter X_MAX, 160, screen width; valid x is 0 to 159.
REQ-003 Parameter Y_MAX, 120, screen height; valid y is 0 to 119.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  command write strobe.
- push_clear  in  1  command is full-screen clear; x/y/colour ignored.
- push_x  in  8  block x.
- push_y  in  7  block y.
- push_colour  in  3  block colour.
- ready_to_draw  in  1  drawer idle indicator.
- enable_start  out  1  one-cycle block-draw request to drawer.
- enable_clear  out  1  one-cycle clear request to drawer.
- x_out  out  8  x presented to drawer.
- y_out  out  7  y presented to drawer.
- colour_out  out  3  colour presented to drawer.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  a command is in flight.
- overflow  out  1  sticky: push dropped because FIFO full.
- bad_coord  out  1  sticky: push dropped because coordinate out of range.
- ack_timeout  out  1  sticky: drawer failed to acknowledge.

Function
REQ-006 FIFO entry = {clear, x, y, colour}; a push is accepted iff push=1, FIFO not full (after any same-cycle pop), and (push_clear=1 or (push_x<X_MAX and push_y<Y_MAX)).
REQ-007 A push when full with no same-cycle pop SHALL be dropped and set overflow; a push when full with a same-cycle pop SHALL be accepted.
REQ-008 A non-clear push with an out-of-range coordinate SHALL be dropped and set bad_coord; FIFO contents are unchanged.
REQ-009 There is no FIFO bypass: an entry accepted at edge k is first visible at the FIFO head in cycle k+1.
REQ-010 FSM states: S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE.
REQ-011 Transition S_IDLE->S_ISSUE occurs when the FIFO is not empty and ready_to_draw=1; on that edge the head is popped into x_out/y_out/colour_out and a clear flag.
REQ-012 In S_ISSUE, exactly one of enable_start (block) or enable_clear (clear) SHALL be 1 for one cycle; the next state is S_WAIT_ACK.
REQ-013 In S_WAIT_ACK:
- ready_to_draw=0 -> S_WAIT_DONE.
- 3 cycles in S_WAIT_ACK with ready_to_draw still 1 -> set ack_timeout and go to S_IDLE.
REQ-014 In S_WAIT_DONE, ready_to_draw=1 -> S_IDLE; otherwise remain, with no timeout (a clear takes about 19200 cycles).
REQ-015 x_out, y_out and colour_out SHALL hold stable from S_ISSUE until the next pop.
REQ-016 busy = 1 in every state except S_IDLE.
REQ-017 Latency: a push into an empty FIFO with the drawer idle SHALL produce enable_start in cycle k+2.
REQ-018 Commands SHALL be issued in FIFO order; at most one command is outstanding.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; occupancy uses a counter that is log2(DEPTH)+1 bits wide.
REQ-020 full and empty are combinational decodes of occupancy.

Reset
REQ-021 When reset=1 at a clock edge: FSM goes to S_IDLE, FIFO is emptied, and all outputs are 0 except empty=1. This includes enable_start, enable_clear, x_out, y_out, colour_out, busy and all sticky flags.
REQ-022 Reset mid-command SHALL abandon the in-flight command without issuing any further strobe; sticky flags clear only on reset.

Verification
REQ-023 Bench SHALL cover:
- Single push x=10, y=20, colour=3 at cycle 0, drawer idle -> enable_start=1 in cycle 2 only, x_out=10, y_out=20, colour_out=3; busy until ready_to_draw returns high.
- 9 pushes back-to-back with the drawer held busy (ready_to_draw=0) -> full=1 after 8 pushes; 9th push dropped, overflow=1; all 8 entries later issued in order.
- Push x=160, y=5 -> dropped, bad_coord=1, empty stays 1; push_clear=1 with x=200 -> accepted, enable_clear pulse, enable_start stays 0.
- Drawer never lowers ready_to_draw after enable_start -> ack_timeout=1 on the 3rd S_WAIT_ACK cycle; next command issued normally.
- reset=1 asserted during S_WAIT_DONE with 3 entries queued -> next cycle empty=1, busy=0, no strobe afterwards.
- Push and pop in the same cycle with FIFO full -> push accepted, full stays 1, overflow stays 0.

Source files
------------

// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : draw_sequencer
// Description : Buffers block-draw and screen-clear commands in a small FIFO
//               and hands them one at a time to a drawer engine using a
//               strobe / ready_to_draw handshake. Reports dropped commands
//               and missing drawer acknowledgements with sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_sequencer #(
    parameter int DEPTH = 8,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       push_clear,
    input  logic [7:0] push_x,
    input  logic [6:0] push_y,
    input  logic [2:0] push_colour,
    input  logic       ready_to_draw,
    output logic       enable_start,
    output logic       enable_clear,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       bad_coord,
    output logic       ack_timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Pointer width; occupancy needs one more bit to represent DEPTH itself.
    localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW        = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    // Coordinate limits widened by one bit so a limit of 256 / 128 still fits.
    localparam logic [8:0]      c_X_LIMIT   = 9'(X_MAX);
    localparam logic [7:0]      c_Y_LIMIT   = 8'(Y_MAX);
    // Index of the last WAIT_ACK cycle tolerated with ready_to_draw still high.
    localparam logic [1:0]      c_ACK_LAST  = 2'd2;

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       clr;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;

    entry_t          r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic            r_cmd_clear;
    logic [7:0]      r_x_out;
    logic [6:0]      r_y_out;
    logic [2:0]      r_colour_out;

    logic            r_overflow;
    logic            r_bad_coord;
    logic            r_ack_timeout;
    logic [1:0]      r_ack_cnt;

    entry_t          w_head;
    entry_t          w_wr_entry;
    logic            w_full;
    logic            w_empty;
    logic            w_coord_ok;
    logic            w_pop;
    logic            w_accept;
    logic            w_drop_full;
    logic            w_drop_coord;
    logic            w_ack_expire;
    logic            w_enable_start;
    logic            w_enable_clear;

    // ------------------------------------------------------------------------
    // FIFO status and push / pop qualification
    // ------------------------------------------------------------------------
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_wr_entry = '{clr: push_clear, x: push_x, y: push_y, colour: push_colour};

    // Clear commands carry no meaningful coordinates, so they skip the range check.
    assign w_coord_ok = push_clear ||
                        (({1'b0, push_x} < c_X_LIMIT) && ({1'b0, push_y} < c_Y_LIMIT));

    // The head leaves the FIFO on the edge that moves the FSM from IDLE to ISSUE.
    assign w_pop        = (r_state == S_IDLE) && !w_empty && ready_to_draw;

    // A full FIFO still has room when its head leaves on the same edge.
    assign w_accept     = push && (!w_full || w_pop) && w_coord_ok;
    assign w_drop_full  = push && w_full && !w_pop;
    assign w_drop_coord = push && !w_coord_ok;

    // Command storage; no reset needed because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Write / read pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy counter: unchanged when a push and a pop coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Command register presented to the drawer
    // ------------------------------------------------------------------------
    // Capture the popped head; held until the next pop so the drawer sees stable data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_clear  <= 1'b0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_colour_out <= '0;
        end else if (w_pop) begin
            r_cmd_clear  <= w_head.clr;
            r_x_out      <= w_head.x;
            r_y_out      <= w_head.y;
            r_colour_out <= w_head.colour;
        end
    end

    // ------------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode. A clear can take ~19200 cycles, so only the
    // acknowledge phase is timed, never the completion phase.
    always_comb begin
        w_state_next   = r_state;
        w_enable_start = 1'b0;
        w_enable_clear = 1'b0;
        w_ack_expire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && ready_to_draw) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_enable_start = !r_cmd_clear;
                w_enable_clear = r_cmd_clear;
                w_state_next   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!ready_to_draw) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    w_ack_expire = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (ready_to_draw) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counts WAIT_ACK cycles in which the drawer has not yet dropped ready_to_draw.
    always_ff @(posedge clk) begin
        if (reset || (r_state != S_WAIT_ACK)) begin
            r_ack_cnt <= '0;
        end else if (ready_to_draw) begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    // Flags only ever set; reset is the sole way to clear them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow    <= 1'b0;
            r_bad_coord   <= 1'b0;
            r_ack_timeout <= 1'b0;
        end else begin
            if (w_drop_full) begin
                r_overflow <= 1'b1;
            end
            if (w_drop_coord) begin
                r_bad_coord <= 1'b1;
            end
            if (w_ack_expire) begin
                r_ack_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign enable_start = w_enable_start;
    assign enable_clear = w_enable_clear;
    assign x_out        = r_x_out;
    assign y_out        = r_y_out;
    assign colour_out   = r_colour_out;
    assign full         = w_full;
    assign empty        = w_empty;
    assign busy         = (r_state != S_IDLE);
    assign overflow     = r_overflow;
    assign bad_coord    = r_bad_coord;
    assign ack_timeout  = r_ack_timeout;

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_sequencer
// Description : Self-checking bench for draw_sequencer. Directed scenarios plus
//               randomized command bursts compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_sequencer;

    localparam int DEPTH = 8;
    localparam int XLIM  = 160;
    localparam int YLIM  = 120;

    typedef struct packed {
        logic       clr;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       push_clear;
    logic [7:0] push_x;
    logic [6:0] push_y;
    logic [2:0] push_colour;
    logic       ready_to_draw;
    logic       enable_start;
    logic       enable_clear;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       bad_coord;
    logic       ack_timeout;

    // Model state: commands accepted but not yet issued, and expected sticky flags.
    cmd_t mq[$];
    logic m_ovf;
    logic m_bad;
    logic m_ack;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    draw_sequencer #(
        .DEPTH(DEPTH),
        .X_MAX(XLIM),
        .Y_MAX(YLIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_clear   (push_clear),
        .push_x       (push_x),
        .push_y       (push_y),
        .push_colour  (push_colour),
        .ready_to_draw(ready_to_draw),
        .enable_start (enable_start),
        .enable_clear (enable_clear),
        .x_out        (x_out),
        .y_out        (y_out),
        .colour_out   (colour_out),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .overflow     (overflow),
        .bad_coord    (bad_coord),
        .ack_timeout  (ack_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One push cycle with the drawer held off, so FIFO occupancy equals the model queue.
    task automatic push_cmd(input logic clr, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c);
        bit   ok;
        cmd_t cmd;
        cmd         = {clr, x, y, c};
        push        = 1'b1;
        push_clear  = clr;
        push_x      = x;
        push_y      = y;
        push_colour = c;
        ok = clr || ((int'(x) < XLIM) && (int'(y) < YLIM));
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        if (!ok) m_bad = 1'b1;
        if (ok && (mq.size() < DEPTH)) mq.push_back(cmd);
        tick();
        push = 1'b0;
        chk("push_full",     full,      32'(mq.size() == DEPTH));
        chk("push_empty",    empty,     32'(mq.size() == 0));
        chk("push_overflow", overflow,  m_ovf);
        chk("push_bad",      bad_coord, m_bad);
        chk("push_busy",     busy,      0);
    endtask

    // Cooperative drawer: acknowledges each strobe by dropping ready for 2..5 cycles.
    task automatic drain(input int budget);
        int   hold = 0;
        bit   seen = 0;
        cmd_t last = '0;
        cmd_t e;
        ready_to_draw = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            tick();
            if (enable_start || enable_clear) begin
                if (mq.size() == 0) begin
                    chk("spurious_strobe", {enable_clear, enable_start}, 0);
                end else begin
                    e = mq.pop_front();
                    chk("strobe_kind", {enable_clear, enable_start}, e.clr ? 2'b10 : 2'b01);
                    chk("issue_x", x_out, e.x);
                    chk("issue_y", y_out, e.y);
                    chk("issue_colour", colour_out, e.c);
                    last = e;
                    seen = 1;
                end
                ready_to_draw = 1'b0;
                hold = $urandom_range(2, 5);
            end else begin
                if (seen) chk("hold_stable", {x_out, y_out, colour_out}, {last.x, last.y, last.c});
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) ready_to_draw = 1'b1;
                end
            end
        end
        chk("drain_all_issued", mq.size(), 0);
        chk("drain_empty",      empty,       1);
        chk("drain_busy",       busy,        0);
        chk("drain_overflow",   overflow,    m_ovf);
        chk("drain_bad",        bad_coord,   m_bad);
        chk("drain_ack",        ack_timeout, m_ack);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t e;
        cmd_t nc;
        int   n;
        reset = 1'b1; push = 1'b0; push_clear = 1'b0;
        push_x = '0; push_y = '0; push_colour = '0; ready_to_draw = 1'b1;
        m_ovf = 1'b0; m_bad = 1'b0; m_ack = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_start",  enable_start, 0);
        chk("rst_clear",  enable_clear, 0);
        chk("rst_xyc",    {x_out, y_out, colour_out}, 0);
        chk("rst_full",   full, 0);
        chk("rst_empty",  empty, 1);
        chk("rst_busy",   busy, 0);
        chk("rst_flags",  {overflow, bad_coord, ack_timeout}, 0);
        reset = 1'b0;
        tick();

        // Single push, drawer idle: strobe two cycles later
        push = 1'b1; push_clear = 1'b0; push_x = 8'd10; push_y = 7'd20; push_colour = 3'd3;
        tick(); push = 1'b0;
        chk("t1_c1_start", enable_start, 0);
        chk("t1_c1_empty", empty, 0);
        tick();
        chk("t1_c2_start", enable_start, 1);
        chk("t1_c2_clear", enable_clear, 0);
        chk("t1_x", x_out, 10);
        chk("t1_y", y_out, 20);
        chk("t1_colour", colour_out, 3);
        chk("t1_c2_busy", busy, 1);
        ready_to_draw = 1'b0;
        tick();
        chk("t1_c3_start", enable_start, 0);
        chk("t1_c3_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_wait_busy", busy, 1);
            chk("t1_wait_start", enable_start, 0);
        end
        ready_to_draw = 1'b1;
        tick();
        chk("t1_idle_busy", busy, 0);

        // Nine pushes with the drawer busy: 8 fill, 9th overflows
        ready_to_draw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_cmd(1'b0, 8'(10 + i * 15), 7'(5 + i * 12), 3'(i));
        end
        chk("t2_full", full, 1);
        chk("t2_overflow", overflow, 1);
        drain(150);

        // Coordinate boundaries and a clear with an out-of-range x
        ready_to_draw = 1'b0;
        push_cmd(1'b0, 8'd160, 7'd5, 3'd1);
        chk("t3_bad", bad_coord, 1);
        chk("t3_empty", empty, 1);
        push_cmd(1'b0, 8'd5, 7'd120, 3'd2);
        push_cmd(1'b0, 8'd159, 7'd119, 3'd4);
        push_cmd(1'b1, 8'd200, 7'd5, 3'd2);
        drain(60);

        // Drawer never acknowledges: timeout after three WAIT_ACK cycles
        ready_to_draw = 1'b1;
        push = 1'b1; push_clear = 1'b0; push_x = 8'd50; push_y = 7'd60; push_colour = 3'd5;
        tick(); push = 1'b0;
        tick();
        chk("t4_start", enable_start, 1);
        tick();
        chk("t4_wa1_busy", busy, 1);
        tick();
        chk("t4_wa2_ack", ack_timeout, 0);
        chk("t4_wa2_busy", busy, 1);
        tick();
        chk("t4_wa3_busy", busy, 1);
        tick();
        chk("t4_ack_set", ack_timeout, 1);
        chk("t4_idle", busy, 0);
        m_ack = 1'b1;
        push = 1'b1; push_clear = 1'b0; push_x = 8'd70; push_y = 7'd80; push_colour = 3'd6;
        tick(); push = 1'b0;
        chk("t4_next_early", enable_start, 0);
        tick();
        chk("t4_next_start", enable_start, 1);
        chk("t4_next_x", x_out, 70);
        chk("t4_next_y", y_out, 80);
        ready_to_draw = 1'b0;
        tick(); tick();
        ready_to_draw = 1'b1;
        tick();
        chk("t4_next_done", busy, 0);
        chk("t4_ack_sticky", ack_timeout, 1);

        // Reset while waiting for completion with three entries queued
        ready_to_draw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 8'(20 + i), 7'(30 + i), 3'(i + 1));
        end
        ready_to_draw = 1'b1;
        tick();
        e = mq.pop_front();
        chk("t5_start", enable_start, 1);
        chk("t5_x", x_out, e.x);
        ready_to_draw = 1'b0;
        tick(); tick();
        chk("t5_wd_busy", busy, 1);
        chk("t5_wd_empty", empty, 0);
        reset = 1'b1;
        tick();
        chk("t5_rst_empty", empty, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_flags", {overflow, bad_coord, ack_timeout}, 0);
        chk("t5_rst_xyc", {x_out, y_out, colour_out}, 0);
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0; m_bad = 1'b0; m_ack = 1'b0;
        ready_to_draw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_no_strobe", {enable_clear, enable_start}, 0);
        end

        // Push into a full FIFO on the same edge as a pop
        ready_to_draw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_cmd(1'b0, 8'($urandom_range(0, XLIM - 1)), 7'($urandom_range(0, YLIM - 1)),
                     3'($urandom));
        end
        nc = {1'b0, 8'd77, 7'd66, 3'd7};
        push = 1'b1; push_clear = nc.clr; push_x = nc.x; push_y = nc.y; push_colour = nc.c;
        ready_to_draw = 1'b1;
        e = mq.pop_front();
        mq.push_back(nc);
        tick();
        push = 1'b0;
        chk("t6_full", full, 1);
        chk("t6_overflow", overflow, 0);
        chk("t6_start", enable_start, 1);
        chk("t6_x", x_out, e.x);
        ready_to_draw = 1'b0;
        tick(); tick();
        drain(150);

        // Randomized bursts against the queue model
        for (int r = 0; r < 6; r++) begin
            ready_to_draw = 1'b0;
            n = $urandom_range(4, 12);
            for (int i = 0; i < n; i++) begin
                push_cmd(1'($urandom_range(0, 4) == 0), 8'($urandom_range(0, 175)),
                         7'($urandom_range(0, 127)), 3'($urandom));
            end
            drain(12 * n + 30);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
